branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Consumes the ALU status flags (zero, negative, overflow, carry) produced in EX for a compare/SUB operation.
- Resolves RISC-V conditional branches and jumps, and issues a PC redirect to fetch over a valid/ready handshake.
- Sequences a multi-cycle flush of the younger pipeline stages.
- Sits between EX and the IF/ID/EX pipeline-register control.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_o stays high after the redirect handshake completes (0 allowed).
- CNT_W, 16, width of the taken-redirect counter.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid_i  input  1  EX holds a control-flow candidate
- ex_branch_i  input  1  op is a conditional branch
- ex_jump_i  input  1  op is JAL/JALR (unconditional)
- ex_funct3_i  input  3  branch condition code
- ex_target_i  input  32  computed target PC
- zero_i  input  1  ALU zero flag
- negative_i  input  1  ALU negative flag
- overflow_i  input  1  ALU signed overflow flag
- carry_i  input  1  ALU carry flag; for SUB, 1 means no borrow (in1 >= in2 unsigned)
- stall_i  input  1  pipeline stall; blocks acceptance
- redirect_ready_i  input  1  fetch accepts redirect
- redirect_valid_o  output  1  redirect request
- redirect_pc_o  output  32  redirect target
- flush_o  output  1  squash IF/ID and ID/EX
- busy_o  output  1  unit not accepting new ops
- illegal_o  output  1  one-cycle pulse on unsupported funct3
- taken_count_o  output  CNT_W  count of completed redirects

Behaviour:
- Reset (async, rst_n=0): state IDLE; redirect_valid_o=0, redirect_pc_o=0, flush_o=0, busy_o=0, illegal_o=0, taken_count_o=0. Asserting reset mid-REDIRECT or mid-FLUSH aborts immediately; no redirect is replayed after release.
- Accept: on a rising edge where state=IDLE, ex_valid_i=1 and stall_i=0.
- Condition evaluation at accept (from the input flags):
  - funct3 000 BEQ: taken = zero_i
  - 001 BNE: taken = !zero_i
  - 100 BLT: taken = negative_i ^ overflow_i
  - 101 BGE: taken = !(negative_i ^ overflow_i)
  - 110 BLTU: taken = !carry_i
  - 111 BGEU: taken = carry_i
  - 010/011: not taken; illegal_o pulses high for exactly the cycle after accept.
- Jump and branch precedence: ex_jump_i=1 means taken regardless of flags and funct3, and it overrides ex_branch_i. If neither is set, the op is ignored.
- Taken path: next state REDIRECT. The cycle after accept (latency 1):
  - redirect_valid_o=1, redirect_pc_o=ex_target_i (captured at accept), flush_o=1, busy_o=1.
- Not-taken path: remain IDLE; no outputs change except illegal_o.
- REDIRECT state:
  - Hold redirect_valid_o, redirect_pc_o and flush_o stable until redirect_ready_i=1 is sampled on an edge.
  - On that edge, taken_count_o increments, wrapping from all-ones to 0.
  - Then go to FLUSH with counter = FLUSH_CYCLES, or go directly to IDLE if FLUSH_CYCLES=0.
  - ready asserted in the first REDIRECT cycle completes the handshake in that same cycle.
- FLUSH state:
  - redirect_valid_o=0; flush_o=1; busy_o=1.
  - Counter decrements each cycle; at 1, the next state is IDLE. flush_o is high for exactly FLUSH_CYCLES cycles after the handshake.
- IDLE state: redirect_valid_o=0, flush_o=0, busy_o=0. redirect_pc_o retains its last value.
- Busy handling: stall_i and ex_valid_i are ignored in REDIRECT/FLUSH. Upstream holds the op; it is accepted on the first IDLE edge with stall_i=0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then BEQ with zero_i=1, target 0x0000_0100, redirect_ready_i=1 -> redirect_valid_o high 1 cycle after accept, redirect_pc_o=0x100; flush_o high for 1+2 cycles; taken_count_o=1.
- BLT with negative_i=1, overflow_i=1 -> not taken, no redirect, busy_o stays 0. BLTU with carry_i=0 -> taken.
- BGEU with carry_i=1, redirect_ready_i held low 5 cycles -> redirect_valid_o and redirect_pc_o stable for 5 cycles; count increments only on the ready edge.
- ex_jump_i=1, ex_branch_i=1, funct3=001, zero_i=1 -> taken (jump overrides). funct3=010 with branch only -> illegal_o one-cycle pulse, no redirect.
- stall_i=1 with ex_valid_i=1 in IDLE -> no accept; deassert stall_i -> accept next edge. rst_n low during FLUSH -> all outputs 0 asynchronously, IDLE after release.
- taken_count_o preloaded to 0xFFFF via 65535 redirects -> next redirect gives 0x0000. FLUSH_CYCLES=0 build -> busy_o drops the cycle after the handshake.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution from EX-stage ALU flags, with a valid/ready PC redirect to fetch
// followed by a fixed-length flush of the younger pipeline stages.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid_i,
    input  logic             ex_branch_i,
    input  logic             ex_jump_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [31:0]      ex_target_i,
    input  logic             zero_i,
    input  logic             negative_i,
    input  logic             overflow_i,
    input  logic             carry_i,
    input  logic             stall_i,
    input  logic             redirect_ready_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             busy_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] taken_count_o
);

    localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StRedirect, StFlush} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [FcW-1:0]     fcnt_q, fcnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               illegal_q, illegal_d;

    logic cond_taken, cond_illegal, accept, taken;

    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = 1'b0;
        case (ex_funct3_i)
            3'b000:  cond_taken = zero_i;
            3'b001:  cond_taken = !zero_i;
            3'b100:  cond_taken = negative_i ^ overflow_i;
            3'b101:  cond_taken = !(negative_i ^ overflow_i);
            // carry means "no borrow", i.e. in1 >= in2 unsigned
            3'b110:  cond_taken = !carry_i;
            3'b111:  cond_taken = carry_i;
            default: cond_illegal = 1'b1;
        endcase
    end

    assign accept    = (state_q == StIdle) && ex_valid_i && !stall_i;
    assign taken     = ex_jump_i || (ex_branch_i && cond_taken);
    assign illegal_d = accept && !ex_jump_i && ex_branch_i && cond_illegal;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fcnt_d  = fcnt_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (accept && taken) begin
                    state_d = StRedirect;
                    pc_d    = ex_target_i;
                end
            end
            StRedirect: begin
                if (redirect_ready_i) begin
                    count_d = count_q + CNT_W'(1);
                    if (FLUSH_CYCLES == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StFlush;
                        fcnt_d  = FcW'(FLUSH_CYCLES);
                    end
                end
            end
            StFlush: begin
                fcnt_d = fcnt_q - FcW'(1);
                if (fcnt_q == FcW'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            fcnt_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fcnt_q    <= fcnt_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    assign redirect_valid_o = (state_q == StRedirect);
    assign redirect_pc_o    = pc_q;
    assign flush_o          = (state_q != StIdle);
    assign busy_o           = (state_q != StIdle);
    assign illegal_o        = illegal_q;
    assign taken_count_o    = count_q;

endmodule
